// File: rtl/breathe_pkg.sv
// Shared types and default constants for the RGB breathing PWM block.
package breathe_pkg;

  // Ramp modes; encoding 3 is treated as HOLD by the slices.
  typedef enum logic [1:0] {
    SAW  = 2'd0,
    TRI  = 2'd1,
    HOLD = 2'd2
  } mode_e;

  localparam int DEF_N_CH        = 3;
  localparam int DEF_R           = 8;
  localparam int DEF_DVSR        = 4882;
  localparam int DEF_STEP_CYCLES = 2500000;

  // Reset duty for a channel: channels start spread evenly across the range.
  function automatic int init_duty(input int ch, input int r, input int n_ch);
    return (ch * (1 << r)) / n_ch;
  endfunction

endpackage

// File: rtl/pwm_slice.sv
// One PWM channel: holds the ramp target, the active duty used by the
// comparator, and the triangle direction bit.
module pwm_slice
  import breathe_pkg::*;
#(
  parameter int R    = DEF_R,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         step,
  input  logic         load,
  input  logic [1:0]   mode,
  input  logic [R-1:0] cnt,
  output logic         pwm,
  output logic [R:0]   duty
);

  localparam logic [R:0] MAX_D  = {1'b1, {R{1'b0}}};
  localparam logic [R:0] MAX_M1 = MAX_D - 1'b1;
  localparam logic [R:0] ZERO_D = '0;
  localparam logic [R:0] ONE_D  = {{R{1'b0}}, 1'b1};
  localparam logic [R:0] INIT_D = (R+1)'(INIT);

  logic [R:0] target;
  logic [R:0] active;
  logic       dir_up;
  logic [R:0] next_target;
  logic       next_dir_up;

  // Next ramp level for the current mode; dir flips on arriving at an endpoint
  // so each endpoint is held for exactly one step.
  always_comb begin
    next_target = target;
    next_dir_up = dir_up;
    case (mode_e'(mode))
      SAW: begin
        next_target = (target == MAX_D) ? ZERO_D : target + ONE_D;
      end
      TRI: begin
        if (dir_up) begin
          if (target == MAX_D) begin
            next_target = MAX_M1;
            next_dir_up = 1'b0;
          end else begin
            next_target = target + ONE_D;
            if (target == MAX_M1) next_dir_up = 1'b0;
          end
        end else begin
          if (target == ZERO_D) begin
            next_target = ONE_D;
            next_dir_up = 1'b1;
          end else begin
            next_target = target - ONE_D;
            if (target == ONE_D) next_dir_up = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Target/dir advance on steps; active duty only changes at a period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= INIT_D;
      active <= INIT_D;
      dir_up <= 1'b1;
    end else begin
      if (load) active <= target;
      if (step) begin
        target <= next_target;
        dir_up <= next_dir_up;
      end
    end
  end

  assign pwm  = !rst && en && ({1'b0, cnt} < active);
  assign duty = active;

endmodule

// File: rtl/rgb_breathe_pwm.sv
// Multi-channel breathing PWM: shared prescaler, PWM counter and step timer,
// with one ramp/compare slice per channel.
module rgb_breathe_pwm
  import breathe_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int R           = DEF_R,
  parameter int DVSR        = DEF_DVSR,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH*(R+1)-1:0]   duty_mon,
  output logic                    period_start
);

  localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = $clog2(STEP_CYCLES);

  localparam logic [PW-1:0] PRE_LAST  = PW'(DVSR - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [R-1:0]  CNT_LAST  = '1;

  logic [PW-1:0] pre;
  logic [R-1:0]  cnt;
  logic [SW-1:0] st;
  logic          tick;
  logic          step;

  assign tick         = en && (pre == PRE_LAST);
  assign step         = en && (st == STEP_LAST);
  assign period_start = tick && (cnt == CNT_LAST);

  // Prescaler and PWM counter; both are cleared while disabled so a resume
  // starts a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
    end else if (!en) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Step timer; holds its position while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '0;
    end else if (en) begin
      st <= step ? '0 : st + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_slice #(
      .R    (R),
      .INIT (init_duty(i, R, N_CH))
    ) u_slice (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .step (step),
      .load (period_start),
      .mode (mode),
      .cnt  (cnt),
      .pwm  (pwm_out[i]),
      .duty (duty_mon[i*(R+1) +: R+1])
    );
  end

endmodule

// File: tb/tb_rgb_breathe_pwm.sv
// Randomized self-checking bench for rgb_breathe_pwm against a behavioural model.
module tb_rgb_breathe_pwm;

  localparam int N_CH  = 3;
  localparam int R     = 3;
  localparam int DVSR  = 2;
  localparam int STEPC = 4;
  localparam int MAXD  = 1 << R;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b1;
  logic [1:0]            mode = 2'd0;
  logic [N_CH-1:0]       pwm_out;
  logic [N_CH*(R+1)-1:0] duty_mon;
  logic                  period_start;

  int n_checks = 0;
  int n_fails  = 0;

  rgb_breathe_pwm #(
    .N_CH        (N_CH),
    .R           (R),
    .DVSR        (DVSR),
    .STEP_CYCLES (STEPC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .pwm_out      (pwm_out),
    .duty_mon     (duty_mon),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Behavioural model state: plain integers for timing and levels.
  int m_pre, m_cnt, m_st;
  int m_tgt[N_CH];
  int m_act[N_CH];
  bit m_up[N_CH];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m, input int n);
    rst  = r;
    en   = e;
    mode = m;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    m_pre = 0;
    m_cnt = 0;
    m_st  = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_tgt[i] = (i * MAXD) / N_CH;
      m_act[i] = m_tgt[i];
      m_up[i]  = 1'b1;
    end
  endtask

  // Triangle ramp as a position on a 2*MAX cycle; level folds back after MAX.
  task automatic triStep(input int i);
    int p;
    p = m_up[i] ? m_tgt[i] : (2*MAXD - m_tgt[i]) % (2*MAXD);
    p = (p + 1) % (2*MAXD);
    m_tgt[i] = (p <= MAXD) ? p : 2*MAXD - p;
    m_up[i]  = (p < MAXD);
  endtask

  task automatic modelAdvance();
    bit tick, stp, ps;
    tick = en && (m_pre == DVSR-1);
    stp  = en && (m_st == STEPC-1);
    ps   = tick && (m_cnt == MAXD-1);
    for (int i = 0; i < N_CH; i++) begin
      if (ps) m_act[i] = m_tgt[i];
      if (stp) begin
        if (mode == 2'd0)      m_tgt[i] = (m_tgt[i] + 1) % (MAXD + 1);
        else if (mode == 2'd1) triStep(i);
      end
    end
    if (!en) begin
      m_pre = 0;
      m_cnt = 0;
    end else begin
      m_pre = tick ? 0 : m_pre + 1;
      if (tick) m_cnt = (m_cnt + 1) % MAXD;
      m_st = stp ? 0 : m_st + 1;
    end
  endtask

  // Compare process: every cycle, DUT outputs against the model's current state.
  always @(negedge clk) begin
    logic [N_CH-1:0]       exp_pwm;
    logic [N_CH*(R+1)-1:0] exp_duty;
    int                    exp_ps;
    if (rst) modelReset();
    for (int i = 0; i < N_CH; i++) begin
      exp_pwm[i] = !rst && en && (m_cnt < m_act[i]);
      exp_duty[i*(R+1) +: R+1] = (R+1)'(m_act[i]);
    end
    exp_ps = (!rst && en && m_pre == DVSR-1 && m_cnt == MAXD-1) ? 1 : 0;
    checkOutput("pwm_out", int'(pwm_out), int'(exp_pwm));
    checkOutput("duty_mon", int'(duty_mon), int'(exp_duty));
    checkOutput("period_start", int'(period_start), exp_ps);
    if (!rst) modelAdvance();
  end

  initial begin
    int c[N_CH];
    int ps_count;

    // Reset state
    @(negedge clk);
    checkOutput("reset_pwm", int'(pwm_out), 0);
    checkOutput("reset_duty", int'(duty_mon), 'h520);
    checkOutput("reset_ps", int'(period_start), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two periods in SAW from reset: counts of high cycles pin the duties
    ps_count = 0;
    for (int i = 0; i < N_CH; i++) c[i] = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ps_count += int'(period_start);
      if (k == 14) checkOutput("ps_before_wrap", int'(period_start), 0);
      if (k == 15) checkOutput("ps_at_wrap", int'(period_start), 1);
      if (k == 16) checkOutput("p2_duty", int'(duty_mon), 'h853);
      for (int i = 0; i < N_CH; i++) c[i] += int'(pwm_out[i]);
      if (k == 15) begin
        checkOutput("p1_ch0_high", c[0], 0);
        checkOutput("p1_ch1_high", c[1], 4);
        checkOutput("p1_ch2_high", c[2], 10);
        for (int i = 0; i < N_CH; i++) c[i] = 0;
      end
    end
    checkOutput("p2_ch0_high", c[0], 6);
    checkOutput("p2_ch1_high", c[1], 10);
    checkOutput("p2_ch2_high", c[2], 16);
    checkOutput("ps_pulses", ps_count, 2);
    @(posedge clk); #1;

    // HOLD, then drop en mid-period and resume
    applyStimulus(1'b0, 1'b1, 2'd2, 41);
    en = 1'b0;
    @(negedge clk);
    checkOutput("en_drop_pwm", int'(pwm_out), 0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'd2, 5);
    applyStimulus(1'b0, 1'b1, 2'd2, 20);

    // Long triangle run across several turnarounds
    applyStimulus(1'b0, 1'b1, 2'd1, 300);

    // Randomized segments of mode, enable and occasional reset
    for (int s = 0; s < 60; s++) begin
      applyStimulus(($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 5) != 0),
                    2'($urandom_range(0, 3)),
                    $urandom_range(1, 30));
    end

    // Reset mid-ramp during triangle descent of ch2
    applyStimulus(1'b1, 1'b1, 2'd1, 2);
    applyStimulus(1'b0, 1'b1, 2'd1, 24);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midramp_reset_duty", int'(duty_mon), 'h520);
    checkOutput("midramp_reset_pwm", int'(pwm_out), 0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 2'd1, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rgb_breathe_pwm.md
RGB_BREATHE_PWM -- requirements
Module: rgb_breathe_pwm

Interface
REQ-001 The block SHALL have parameter N_CH, default 3, meaning the number of independent PWM channels.
REQ-002 The block SHALL have parameter R, default 8, meaning the PWM resolution in bits.
REQ-003 The block SHALL have parameter DVSR, default 4882, meaning the number of clk cycles per PWM counter tick (minimum 1).
REQ-004 The block SHALL have parameter STEP_CYCLES, default 2500000, meaning the number of clk cycles per ramp step (minimum 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the clock.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous, active-high.
REQ-007 The block SHALL have port en, input, 1 bit: the global run enable.
REQ-008 The block SHALL have port mode, input, 2 bits: ramp mode, where 0=SAW, 1=TRI, 2=HOLD and 3=HOLD.
REQ-009 The block SHALL have port pwm_out, output, N_CH bits: one PWM output per channel.
REQ-010 The block SHALL have port duty_mon, output, N_CH*(R+1) bits: the active duty of each channel, with channel i in bits [i*(R+1) +: R+1].
REQ-011 The block SHALL have port period_start, output, 1 bit: a one-cycle pulse at every PWM period boundary.

Function
REQ-012 Prescaler: counts 0..DVSR-1 while en=1; the cycle it equals DVSR-1 is a tick, after which it returns to 0.
REQ-013 PWM counter: R bits, incremented on each tick, wrapping from 2^R-1 to 0; period_start pulses in the cycle the counter wraps to 0.
REQ-014 pwm_out[i] = 1 iff pwm counter < active_duty[i] (unsigned, R+1 bits).
REQ-015 Duty endpoints: active_duty = 0 gives a constant 0 output; active_duty = 2^R gives a constant 1 output.
REQ-016 Step timer: counts 0..STEP_CYCLES-1 while en=1; a step pulse is generated when it reaches STEP_CYCLES-1.
REQ-017 On a step, each channel's target_duty[i] (R+1 bits) updates per mode.
REQ-018 SAW step: 0,1,...,2^R, then 0 (2^R+1 levels, no value above 2^R).
REQ-019 TRI step: a per-channel direction bit; up until 2^R, then dir=down; down until 0, then dir=up. The endpoint values are each held for exactly one step.
REQ-020 HOLD step: target_duty and dir are unchanged.
REQ-021 Mode change mid-ramp: takes effect at the next step with the current target_duty. Entering TRI keeps dir; entering SAW ignores dir.
REQ-022 Glitch-free update: active_duty[i] is loaded from target_duty[i] only in the period_start cycle, so a PWM period never mixes two duties.
REQ-023 Simultaneous step and period_start: active_duty loads the pre-step target; the new target loads at the next boundary.
REQ-024 en=0: pwm_out is forced to 0 the same cycle; prescaler and PWM counter are cleared; step timer, target_duty, active_duty and dir hold.
REQ-025 On en rising: operation resumes from counter 0 with the held duties.
REQ-026 duty_mon reflects active_duty.

Reset
REQ-027 On rst: prescaler, PWM counter and step timer are set to 0; pwm_out=0; period_start=0.
REQ-028 On rst: target_duty[i] = active_duty[i] = (i*2^R)/N_CH (integer division); dir[i] = up.
REQ-029 Reset is asynchronous assert with synchronous deassert assumed upstream; rst mid-ramp discards all state within the cycle of assertion.

Structure
REQ-030 Shared package breathe_pkg SHALL hold the mode_e enum (SAW, TRI, HOLD) and the default parameter constants.
REQ-031 A sub-module pwm_slice (one per channel, generate loop) SHALL hold target/active duty, dir, the ramp logic and the compare. The top SHALL hold the prescaler, PWM counter and step timer.
REQ-032 All flops SHALL be in clk domain only; no derived clocks; ticks and steps are enables.

Verification (R=3, DVSR=2, STEP_CYCLES=4, N_CH=3)
REQ-033 Reset: assert rst -> pwm_out=000; duty_mon = {5,2,0} (ch2,ch1,ch0); period_start=0.
REQ-034 Duty endpoints: with a channel at 0 and at 8 -> output constant 0 and constant 1 across 16 clk (one full period).
REQ-035 SAW wrap: ch0 from 0 -> target sequence 1..8,0 at 4-clk intervals; active_duty changes only on period_start.
REQ-036 TRI turnaround: ch2 from 5 up -> 6,7,8,7,6,...,0,1; both 8 and 0 appear exactly once per turnaround.
REQ-037 HOLD and en: switch to HOLD -> duties are frozen. Then drop en mid-period -> pwm_out=0 that cycle. Raise en -> counter restarts at 0 and duty_mon is unchanged.
REQ-038 Reset mid-ramp: assert rst during TRI descent -> dir returns to up and duties return to the REQ-028 values immediately.
